// File: rtl/mult_div_seq_pkg.sv
// Shared types and constants for the multicycle multiply/divide sequencer.
package mult_div_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } md_state_t;
endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the main control FSM (master) and the MULT/DIV sequencer (slave).
// Carries op_unsigned only when MULT_DIV_SEQ_UNSIGNED_EN is defined.
interface mult_div_seq_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
  logic             op_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
    output op_unsigned,
`endif
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
    input  op_unsigned,
`endif
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_seq_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a 2W+1 bit accumulator.
// MULT: acc = {partial product, multiplier}; DIV: acc = {remainder (W+1), dividend/quotient}.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  md_op_t           op_i,
  output logic [2*WIDTH:0] acc_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (op_i == MD_MULT)
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    else if (rem_sh >= {1'b0, opnd_i})
      acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
    else
      acc_o = {rem_sh, acc_i[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/mult_div_seq.sv
// Multicycle MULT/DIV sequencer: magnitude iteration in md_step, sign fix-up before HI/LO write.
// Define MULT_DIV_SEQ_UNSIGNED_EN to add op_unsigned (MULTU/DIVU) on the interface.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_seq_if.slave  bus
);
  localparam int AW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state_q, state_d;
  md_op_t           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d, step_acc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             uns_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes are taken from the latched operands; unsigned ops bypass the sign capture.
  assign a_neg = ~uns_q & a_q[WIDTH-1];
  assign b_neg = ~uns_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign prod  = qneg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quot  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .op_i   (op_q),
    .acc_o  (step_acc)
  );

`ifdef MULT_DIV_SEQ_UNSIGNED_EN
  logic uns_d;
`else
  assign uns_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
    uns_d   = uns_q;
`endif
    case (state_q)
      IDLE: begin
        dz_d = 1'b0;
        if (bus.start) begin
          op_d    = md_op_t'(bus.op);
          a_d     = bus.a;
          b_d     = bus.b;
`ifdef MULT_DIV_SEQ_UNSIGNED_EN
          uns_d   = bus.op_unsigned;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d  = '0;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        if (op_q == MD_DIV && b_q == '0) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          acc_d   = {{(WIDTH+1){1'b0}}, (op_q == MD_MULT) ? b_mag : a_mag};
          opnd_d  = (op_q == MD_MULT) ? a_mag : b_mag;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q == MD_MULT) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MULT_DIV_SEQ_UNSIGNED_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) uns_q <= 1'b0;
    else        uns_q <= uns_d;
  end
`endif

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = (state_q == DONE) & dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule
